// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the line-wide memory arbiter.
// master is the arbiter's view; slave is the view of the caches and memory around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_done;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] d_wb_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wb_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output i_read, i_addr, d_read, d_write, d_addr, d_wb_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one line-wide memory port between icache and dcache.
// Define MEM_ARB_DATA_PRIO_EN to give the dcache fixed priority whenever both request.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int OFF_W  = 5
) (
    input logic           CLK,
    input logic           RST_N,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, I_RD, D_WB, D_RD, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              i_req, d_req, pick_d;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARB_DATA_PRIO_EN
    assign pick_d = d_req;
`else
    // last_d_q set means the dcache won last time, so a tie goes to the icache
    assign pick_d = d_req & ~(i_req & last_d_q);
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (i_req | d_req) state_d = !pick_d ? I_RD : bus.d_write ? D_WB : D_RD;
            I_RD, D_RD: if (bus.mem_ack) state_d = DONE;
            D_WB:       if (bus.mem_ack) state_d = bus.d_read ? D_RD : DONE;
            DONE:       state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        case (state_q)
            IDLE: if (i_req | d_req) begin
                last_d_d    = pick_d;
                mem_req_d   = 1'b1;
                mem_we_d    = pick_d & bus.d_write;
                mem_addr_d  = !pick_d ? align(bus.i_addr) :
                              bus.d_write ? align(bus.d_wb_addr) : align(bus.d_addr);
                mem_wdata_d = (pick_d & bus.d_write) ? bus.d_wdata : '0;
            end
            I_RD: if (bus.mem_ack) begin
                i_rdata_d   = bus.mem_rdata;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                i_done_d    = 1'b1;
            end
            // a pending fill follows the write-back with mem_req held high
            D_WB: if (bus.mem_ack) begin
                mem_req_d   = bus.d_read;
                mem_we_d    = 1'b0;
                mem_addr_d  = bus.d_read ? align(bus.d_addr) : '0;
                mem_wdata_d = '0;
                d_done_d    = ~bus.d_read;
            end
            D_RD: if (bus.mem_ack) begin
                d_rdata_d   = bus.mem_rdata;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                d_done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_done    = i_done_q;
    assign bus.d_done    = d_done_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// A memory responder logs every completed transaction; each done pulse is matched against the expected list.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
`ifdef MEM_ARB_DATA_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    typedef struct {
        bit          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int          start;
        int          ackc;
    } txn_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .OFF_W(5)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    int n_chk = 0, n_fail = 0, cyc = 0, lat = 1, done_cyc = 0;
    bit spur = 1'b0, model_last_d = 1'b0;
    txn_t log_q[$];
    txn_t got[2];
    logic [AW-1:0] ia, da, dwa;
    logic [LW-1:0] dwd;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~32'h1f;
    endfunction

    function automatic txn_t mk(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.rdata = '0; t.start = 0; t.ackc = 0;
        return t;
    endfunction

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // memory model: acks after lat cycles of mem_req and logs the transaction
    initial begin
        automatic int cnt = 0;
        automatic txn_t cur = mk(0, '0, '0);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            bus.mem_ack = 1'b0;
            if (!RST_N) begin
                cnt = 0;
            end else if (spur) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = rnd_line();
                spur = 1'b0;
            end else if (bus.mem_req) begin
                if (cnt == 0) begin
                    cur = mk(bus.mem_we, bus.mem_addr, bus.mem_wdata);
                    cur.start = cyc;
                    if (!bus.mem_we) chk("rd_wdata_zero", bus.mem_wdata, '0);
                end else begin
                    chk("stable", {bus.mem_we, bus.mem_addr, bus.mem_wdata},
                        {cur.we, cur.addr, cur.wdata});
                end
                if (cnt >= lat) begin
                    bus.mem_rdata = rnd_line();
                    cur.rdata = bus.mem_rdata;
                    cur.ackc = cyc;
                    log_q.push_back(cur);
                    bus.mem_ack = 1'b1;
                    cnt = 0;
                end else cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #3;
    endtask

    task automatic wait_done(output bit gi, output bit gd);
        automatic int n = 0;
        gi = 0; gd = 0;
        while (!(gi | gd) && n < 60) begin
            tick();
            gi = bus.i_done; gd = bus.d_done; n++;
        end
        done_cyc = cyc;
        chk("done_timeout", gi | gd, 1);
    endtask

    task automatic check_port(input bit is_d, input int first_start, input logic [LW-1:0] prev);
        txn_t e[$];
        logic [LW-1:0] rd_exp;
        if (!is_d) e.push_back(mk(0, align(ia), '0));
        else begin
            if (bus.d_write) e.push_back(mk(1, align(dwa), dwd));
            if (bus.d_read) e.push_back(mk(0, align(da), '0));
        end
        chk("txn_count", log_q.size(), e.size());
        if (log_q.size() == e.size() && e.size() > 0) begin
            for (int k = 0; k < e.size(); k++) begin
                chk("txn_we", log_q[k].we, e[k].we);
                chk("txn_addr", log_q[k].addr, e[k].addr);
                chk("txn_wdata", log_q[k].wdata, e[k].wdata);
                got[k] = log_q[k];
            end
            if (e.size() == 2) chk("no_gap", log_q[1].start, log_q[0].ackc + 1);
            if (first_start >= 0) chk("req_latency", log_q[0].start, first_start);
            chk("done_latency", done_cyc, log_q[e.size()-1].ackc + 1);
            rd_exp = e[e.size()-1].we ? prev : log_q[e.size()-1].rdata;
            chk(is_d ? "d_rdata" : "i_rdata", is_d ? bus.d_rdata : bus.i_rdata, rd_exp);
        end
        log_q.delete();
    endtask

    // request both ports as given from IDLE and retire every resulting transaction
    task automatic serve(input bit ir, input bit dr, input bit dw, input int lat_v);
        bit pi, pd, gi, gd, win_d;
        int c0;
        logic [LW-1:0] ip, dp;
        lat = lat_v;
        c0 = cyc;
        ip = bus.i_rdata; dp = bus.d_rdata;
        bus.i_read = ir; bus.d_read = dr; bus.d_write = dw;
        pi = ir; pd = dr | dw;
        while (pi | pd) begin
            win_d = pd && (!pi || PRIO || !model_last_d);
            model_last_d = win_d;
            wait_done(gi, gd);
            if (!(gi | gd)) break;
            chk("winner_d", gd, win_d);
            chk("done_onehot", gi & gd, 0);
            check_port(gd, (c0 >= 0) ? c0 + 1 : -1, gd ? dp : ip);
            if (gd) begin bus.d_read = 0; bus.d_write = 0; pd = 0; end
            else begin bus.i_read = 0; pi = 0; end
            c0 = -1;
            tick();
            chk("done_one_cycle", {bus.i_done, bus.d_done}, 0);
        end
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        tick();
        tick();
        chk("rst_outs", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done, bus.d_done}, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        RST_N = 1'b1;
        model_last_d = 1'b0;
        tick();
    endtask

    initial begin
        bit gi, gd, win_d;
        logic [LW-1:0] ip, dp;
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        bus.i_addr = '0; bus.d_addr = '0; bus.d_wb_addr = '0; bus.d_wdata = '0;
        do_reset();

        // reset while a write-back is outstanding
        dwa = 32'h0000_8040; dwd = rnd_line(); da = 32'h0000_2008;
        bus.d_wb_addr = dwa; bus.d_wdata = dwd; bus.d_addr = da;
        lat = 6;
        bus.d_write = 1; bus.d_read = 1;
        tick(); tick();
        chk("wb_inflight", {bus.mem_req, bus.mem_we}, 2'b11);
        #1 RST_N = 1'b0;
        #1;
        chk("async_rst", {bus.mem_req, bus.mem_we, bus.d_done, bus.mem_addr}, 0);
        chk("async_rst_wdata", bus.mem_wdata, 0);
        bus.d_write = 0; bus.d_read = 0;
        tick();
        RST_N = 1'b1;
        model_last_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_idle", {bus.mem_req, bus.i_done, bus.d_done}, 0);
        end
        chk("post_rst_log", log_q.size(), 0);

        // icache fill, ack two cycles after mem_req
        ia = 32'h0000_1234; bus.i_addr = ia;
        serve(1, 0, 0, 2);
        chk("t_i_addr", got[0].addr, 32'h0000_1220);
        chk("t_i_we", got[0].we, 0);

        // combined write-back + fill
        dwa = 32'h0000_8040; dwd = rnd_line(); da = 32'h0000_2008;
        bus.d_wb_addr = dwa; bus.d_wdata = dwd; bus.d_addr = da;
        serve(0, 1, 1, 1);
        chk("t_wb_addr", got[0].addr, 32'h0000_8040);
        chk("t_wb_data", got[0].wdata, dwd);
        chk("t_fill_addr", got[1].addr, 32'h0000_2000);

        // write-back only
        dwa = 32'h0000_00FF; bus.d_wb_addr = dwa;
        serve(0, 0, 1, 0);
        chk("t_wbonly_addr", got[0].addr, 32'h0000_00E0);

        // spurious ack while idle
        ip = bus.i_rdata; dp = bus.d_rdata;
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("spur_quiet", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.i_done, bus.d_done}, 0);
        end
        chk("spur_rdata", {bus.i_rdata, bus.d_rdata}, {ip, dp});
        chk("spur_log", log_q.size(), 0);

        // persistent tie from reset: the winner re-requests right after its done
        do_reset();
        ia = 32'h0000_4444; da = 32'h0000_5555;
        bus.i_addr = ia; bus.d_addr = da;
        lat = 1;
        bus.i_read = 1; bus.d_read = 1;
        for (int k = 0; k < 4; k++) begin
            ip = bus.i_rdata; dp = bus.d_rdata;
            win_d = PRIO || !model_last_d;
            model_last_d = win_d;
            wait_done(gi, gd);
            chk("tie_winner_d", gd, win_d);
            check_port(gd, -1, gd ? dp : ip);
            if (gd) bus.d_read = 0; else bus.i_read = 0;
            tick();
            chk("tie_one_cycle", {bus.i_done, bus.d_done}, 0);
            if (k < 3) begin bus.i_read = 1; bus.d_read = 1; end
        end
        bus.i_read = 0; bus.d_read = 0;
        tick();

        // randomized mixes of requests
        for (int n = 0; n < 25; n++) begin
            bit ir, dr, dw;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!(ir | dr | dw)) ir = 1;
            ia = $urandom; da = $urandom; dwa = $urandom; dwd = rnd_line();
            bus.i_addr = ia; bus.d_addr = da; bus.d_wb_addr = dwa; bus.d_wdata = dwd;
            serve(ir, dr, dw, $urandom_range(0, 3));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 256-bit line-wide main-memory port between the instruction cache and the data cache.
- Accepts line-fill and dirty-line write-back requests from both caches.
- Arbitrates round-robin and sequences a combined data-cache write-back + fill as two back-to-back memory transactions.
- Sits between the two caches and the memory controller; one transaction is outstanding at a time.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits
OFF_W, 5, line offset bits; forced to zero on mem_addr

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
i_read  in  1  icache fill request, level, held until i_done
i_addr  in  ADDR_W  icache fill address
i_rdata  out  LINE_W  fill line for icache
i_done  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache fill request, level, held until d_done
d_write  in  1  dcache write-back request, level, held until d_done
d_addr  in  ADDR_W  dcache fill address
d_wb_addr  in  ADDR_W  dcache victim line address
d_wdata  in  LINE_W  victim line data
d_rdata  out  LINE_W  fill line for dcache
d_done  out  1  one-cycle completion pulse to dcache
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  ADDR_W  line-aligned address
mem_wdata  out  LINE_W  write data; zero when mem_we=0
mem_rdata  in  LINE_W  read data; valid when mem_ack=1
mem_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE, last_grant=I.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, i_done, d_done.
  - An in-flight transaction is abandoned; no done pulse is issued.
- States: IDLE, I_RD, D_WB, D_RD, DONE. All outputs are registered.
- IDLE: sample requests. i_req=i_read; d_req=d_read|d_write.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant. Reset value I means D wins the first tie.
  - Grant I: next=I_RD, mem_req=1, mem_we=0, mem_addr={i_addr[ADDR_W-1:OFF_W],0}.
  - Grant D with d_write=1: next=D_WB, mem_req=1, mem_we=1, mem_addr=aligned d_wb_addr, mem_wdata=d_wdata.
  - Grant D with d_write=0: next=D_RD, read of aligned d_addr.
  - last_grant updates on grant.
- mem_req rises the cycle after the request is sampled in IDLE (1-cycle arbitration latency).
- I_RD / D_RD: hold mem_req, mem_addr stable until mem_ack.
  - On mem_ack: latch mem_rdata into i_rdata/d_rdata, drop mem_req, next=DONE.
- D_WB: on mem_ack:
  - d_read=1: next=D_RD. Fill issued the following cycle with mem_we=0, mem_wdata=0, mem_addr=aligned d_addr, mem_req kept 1 with no bubble.
  - d_read=0: next=DONE (write-only).
- DONE: the granted port's done=1 for exactly one cycle; all requests ignored; next=IDLE.
  - Requester must deassert before the following edge.
- i_rdata/d_rdata hold their last fill value until the next fill for that port.
- mem_ack while in IDLE or DONE: ignored.
- Request withdrawn mid-transaction: protocol violation; arbiter still completes the transaction and pulses done.
- mem_ack in the same cycle mem_req is first asserted: legal, treated normally.
- Minimum latency for a read with ack one cycle after mem_req: request→done = 3 cycles. Write-back + fill = 5 cycles.
- Addresses are never modified except clearing the OFF_W low bits.

Optional Feature:
- Macro: MEM_ARB_DATA_PRIO_EN.
- Defined: fixed priority. D always wins when both request in IDLE; last_grant is unused.
- Undefined: round-robin as above.

Test Plan:
- Reset mid-D_WB (RST_N low while mem_req=1) → mem_req, mem_we, mem_wdata, d_done drop to 0 asynchronously. After release, state is IDLE and no done pulse is issued.
- i_read=1, i_addr=0x0000_1234, memory acks 2 cycles after mem_req with mem_rdata=pattern A:
  - mem_addr=0x0000_1220, mem_we=0.
  - i_rdata=A.
  - i_done pulses once, 1 cycle after ack.
- d_write=1, d_read=1, d_wb_addr=0x0000_8040, d_wdata=B, d_addr=0x0000_2008:
  - First transaction: write to 0x8040 with data B.
  - Next cycle: read of 0x2000 with mem_wdata=0 and no idle gap.
  - One d_done pulse only, after the read ack.
- i_read and d_read asserted together from reset, both re-requested after each done:
  - Grants alternate D, I, D, I.
  - With MEM_ARB_DATA_PRIO_EN defined, D wins every tie.
- d_write=1, d_read=0, d_wb_addr=0x0000_00FF → single write to 0x0000_00E0, then d_done; d_rdata unchanged.
- Spurious mem_ack in IDLE with no requests → no state change, no done pulses, outputs remain 0.
